// File: rtl/spix_pkg.sv
// Shared definitions for the SPIX/sLiSCP SB-box datapath: rotation amounts and FSM state encoding.
package spix_pkg;
   localparam int SB_ROT_A = 5;
   localparam int SB_ROT_B = 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} sb_state_t;
endpackage

// File: rtl/sb_round.sv
// One Simeck-style Feistel round, purely combinational; rotations wrap modulo W.
module sb_round
   import spix_pkg::*;
#(
   parameter int W = 32
) (
   input  logic [W-1:0] l,
   input  logic [W-1:0] r,
   input  logic         rc_bit,
   output logic [W-1:0] l_nxt,
   output logic [W-1:0] r_nxt
);
   localparam int RA = SB_ROT_A % W;
   localparam int RB = SB_ROT_B % W;

   logic [W-1:0] rot_a;
   logic [W-1:0] rot_b;
   logic [W-1:0] c;

   // a zero rotation degenerates cleanly: the right shift by W yields 0
   assign rot_a = (l << RA) | (l >> (W - RA));
   assign rot_b = (l << RB) | (l >> (W - RB));
   assign c     = {{(W-1){1'b1}}, rc_bit};

   assign l_nxt = (rot_a & l) ^ rot_b ^ r ^ c;
   assign r_nxt = l;
endmodule

// File: rtl/sb_core.sv
// Parametrised SB box: ROUNDS Feistel rounds on a 2W-bit word, UNROLL rounds per clock,
// valid/ready on both sides with back-to-back acceptance out of DONE.
//
//   state | meaning
//   IDLE  | waiting for a word, in_ready high
//   RUN   | UNROLL rounds applied per cycle, cnt tracks the first round of the group
//   DONE  | result held on x_out until out_ready; may accept the next word
module sb_core
   import spix_pkg::*;
#(
   parameter int W      = 32,
   parameter int ROUNDS = 8,
   parameter int UNROLL = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2*W-1:0]    x_in,
   input  logic [ROUNDS-1:0] rc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [2*W-1:0]    x_out
);
   localparam int CW = $clog2(ROUNDS) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(ROUNDS - UNROLL);
   localparam logic [CW-1:0] CNT_STEP = CW'(UNROLL);

   if (ROUNDS < 1 || UNROLL < 1 || (ROUNDS % UNROLL) != 0) begin : g_bad_cfg
      $error("sb_core: UNROLL must be >= 1 and divide ROUNDS");
   end

   sb_state_t         state, state_d;
   logic [2*W-1:0]    x_q;
   logic [ROUNDS-1:0] rc_q;
   logic [UNROLL-1:0] rc_win;
   logic [CW-1:0]     cnt;
   logic              accept;
   logic [W-1:0]      l_ch [UNROLL+1];
   logic [W-1:0]      r_ch [UNROLL+1];

   assign l_ch[0] = x_q[2*W-1:W];
   assign r_ch[0] = x_q[W-1:0];
   assign rc_win  = UNROLL'(rc_q >> cnt);

   for (genvar j = 0; j < UNROLL; j++) begin : g_round
      sb_round #(.W(W)) u_round (
         .l      (l_ch[j]),
         .r      (r_ch[j]),
         .rc_bit (rc_win[j]),
         .l_nxt  (l_ch[j+1]),
         .r_nxt  (r_ch[j+1])
      );
   end

   assign accept = in_valid & in_ready;
   assign x_out  = x_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         x_q   <= '0;
         rc_q  <= '0;
         cnt   <= '0;
      end else begin
         state <= state_d;
         if (accept) begin
            x_q  <= x_in;
            rc_q <= rc;
            cnt  <= '0;
         end else if (state == RUN) begin
            x_q <= {l_ch[UNROLL], r_ch[UNROLL]};
            if (cnt != CNT_LAST) begin
               cnt <= cnt + CNT_STEP;
            end
         end
      end
   end

   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (in_valid) state_d = RUN;
         RUN:     if (cnt == CNT_LAST) state_d = DONE;
         DONE:    if (out_ready) state_d = in_valid ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
      out_valid = (state == DONE);
   end
endmodule

// File: tb/tb_sb_core.sv
// Scoreboard bench for sb_core across several W/ROUNDS/UNROLL configurations.
module tb_sb_core;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // d0: defaults (W=32, ROUNDS=8, UNROLL=2)
   logic        v0 = 0, ord0 = 0, ir0, ov0;
   logic [63:0] x0 = '0, xo0;
   logic [7:0]  rc0 = '0;
   // d1: SB48 (W=24, ROUNDS=8, UNROLL=4)
   logic        v1 = 0, ord1 = 0, ir1, ov1;
   logic [47:0] x1 = '0, xo1;
   logic [7:0]  rc1 = '0;
   // d2/d3/d4: small directed configurations sharing stimulus
   logic        vd = 0, ordd = 0;
   logic [63:0] xz = '0;
   logic        ir2, ov2, ir3, ov3, ir4, ov4;
   logic [63:0] xo2, xo3, xo4;
   logic [1:0]  rc2 = 2'b00, rc4 = 2'b00;
   logic [0:0]  rc3 = 1'b1;

   sb_core #(.W(32), .ROUNDS(8), .UNROLL(2)) u_d0 (
      .clk(clk), .rst(rst), .in_valid(v0), .in_ready(ir0), .x_in(x0), .rc(rc0),
      .out_valid(ov0), .out_ready(ord0), .x_out(xo0));
   sb_core #(.W(24), .ROUNDS(8), .UNROLL(4)) u_d1 (
      .clk(clk), .rst(rst), .in_valid(v1), .in_ready(ir1), .x_in(x1), .rc(rc1),
      .out_valid(ov1), .out_ready(ord1), .x_out(xo1));
   sb_core #(.W(32), .ROUNDS(2), .UNROLL(1)) u_d2 (
      .clk(clk), .rst(rst), .in_valid(vd), .in_ready(ir2), .x_in(xz), .rc(rc2),
      .out_valid(ov2), .out_ready(ordd), .x_out(xo2));
   sb_core #(.W(32), .ROUNDS(1), .UNROLL(1)) u_d3 (
      .clk(clk), .rst(rst), .in_valid(vd), .in_ready(ir3), .x_in(xz), .rc(rc3),
      .out_valid(ov3), .out_ready(ordd), .x_out(xo3));
   sb_core #(.W(32), .ROUNDS(2), .UNROLL(2)) u_d4 (
      .clk(clk), .rst(rst), .in_valid(vd), .in_ready(ir4), .x_in(xz), .rc(rc4),
      .out_valid(ov4), .out_ready(ordd), .x_out(xo4));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [31:0] rotl(input logic [31:0] v, input int a, input int w,
                                        input logic [31:0] m);
      return ((v << a) | (v >> (w - a))) & m;
   endfunction

   function automatic logic [63:0] sb_model(input logic [63:0] x, input logic [7:0] rcv,
                                            input int w, input int r);
      logic [31:0] m, l, rr, t, c;
      m  = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
      l  = 32'(x >> w) & m;
      rr = 32'(x) & m;
      for (int i = 0; i < r; i++) begin
         c  = (m & ~32'h1) | {31'b0, rcv[i]};
         t  = ((rotl(l, 5, w, m) & l) ^ rotl(l, 1, w, m) ^ rr ^ c) & m;
         rr = l;
         l  = t;
      end
      return ({32'b0, l} << w) | {32'b0, rr};
   endfunction

   logic [63:0] exp0[$];
   logic [63:0] exp1[$];
   logic        stream0 = 0, stream1 = 0, have0 = 0, have1 = 0;
   int          last0 = 0, last1 = 0;

   // Streaming period is ROUNDS/UNROLL RUN cycles plus the DONE cycle that accepts the next word.
   always @(negedge clk) begin
      if (rst) exp0.delete();
      else begin
         if (v0 && ir0) exp0.push_back(sb_model(x0, rc0, 32, 8));
         if (ov0 && ord0) begin
            chk("d0_sb_nonempty", 64'(exp0.size() != 0), 64'd1);
            if (exp0.size() != 0) chk("d0_data", xo0, exp0.pop_front());
            if (stream0 && have0) chk("d0_gap", 64'(cyc - last0), 64'd5);
            last0 = cyc;
            have0 = stream0;
         end
         if (!stream0) have0 = 0;
      end
   end

   always @(negedge clk) begin
      if (rst) exp1.delete();
      else begin
         if (v1 && ir1) exp1.push_back(sb_model({16'b0, x1}, rc1, 24, 8));
         if (ov1 && ord1) begin
            chk("d1_sb_nonempty", 64'(exp1.size() != 0), 64'd1);
            if (exp1.size() != 0) chk("d1_data", {16'b0, xo1}, exp1.pop_front());
            if (stream1 && have1) chk("d1_gap", 64'(cyc - last1), 64'd3);
            last1 = cyc;
            have1 = stream1;
         end
         if (!stream1) have1 = 0;
      end
   end

   initial begin
      logic [63:0] exp_a;
      int n, t;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("rst_in_ready", 64'(ir0), 64'd1);
      chk("rst_out_valid", 64'(ov0), 64'd0);
      chk("rst_x_out", xo0, 64'd0);
      chk("rst_d2_x_out", xo2, 64'd0);

      // Directed vectors: ROUNDS=2/UNROLL=1 (2 cycles), ROUNDS=2/UNROLL=2 and ROUNDS=1 (1 cycle)
      @(posedge clk); #1 vd = 1;
      @(posedge clk); #1 vd = 0;
      @(posedge clk); @(negedge clk);
      chk("d2_ov_early", 64'(ov2), 64'd0);
      chk("d3_ov", 64'(ov3), 64'd1);
      chk("d3_x_out", xo3, 64'hFFFFFFFF_00000000);
      chk("d4_ov", 64'(ov4), 64'd1);
      chk("d4_x_out", xo4, 64'hFFFFFFDD_FFFFFFFE);
      @(posedge clk); @(negedge clk);
      chk("d2_ov", 64'(ov2), 64'd1);
      chk("d2_x_out", xo2, 64'hFFFFFFDD_FFFFFFFE);
      chk("d4_hold", xo4, 64'hFFFFFFDD_FFFFFFFE);
      #1 ordd = 1;

      // Default latency: out_valid exactly 4 edges after acceptance
      @(posedge clk); #1 v0 = 1; ord0 = 1; x0 = {$urandom, $urandom}; rc0 = 8'($urandom);
      @(posedge clk); #1 v0 = 0;
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk); @(negedge clk);
         chk("d0_latency", 64'(ov0), 64'(i == 4));
      end

      // Streaming with in_valid held high
      @(posedge clk); #1 stream0 = 1; v0 = 1; x0 = {$urandom, $urandom}; rc0 = 8'($urandom);
      n = 0; t = 0;
      while (n < 20 && t < 400) begin
         @(negedge clk);
         if (ir0) n++;
         @(posedge clk); #1;
         if (n > 0 && ir0 == 0) begin end
         x0 = {$urandom, $urandom}; rc0 = 8'($urandom);
         t++;
      end
      v0 = 0;
      t = 0;
      while (exp0.size() != 0 && t < 50) begin @(posedge clk); t++; end
      chk("d0_stream_drain", 64'(exp0.size()), 64'd0);
      stream0 = 0;

      // Back-pressure: result held, new word ignored, then handshake with same-cycle accept
      @(posedge clk); #1 ord0 = 0; v0 = 1; x0 = {$urandom, $urandom}; rc0 = 8'($urandom);
      exp_a = sb_model(x0, rc0, 32, 8);
      @(posedge clk); #1 x0 = {$urandom, $urandom}; rc0 = 8'($urandom);
      t = 0;
      while (!ov0 && t < 20) begin @(negedge clk); t++; end
      chk("bp_ov_rise", 64'(ov0), 64'd1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_ov_hold", 64'(ov0), 64'd1);
         chk("bp_x_hold", xo0, exp_a);
         chk("bp_in_ready", 64'(ir0), 64'd0);
      end
      @(posedge clk); #1 ord0 = 1;
      @(posedge clk); #1 v0 = 0;
      @(negedge clk);
      chk("bp_ov_drop", 64'(ov0), 64'd0);
      chk("bp_next_run", 64'(ir0), 64'd0);
      t = 0;
      while (exp0.size() != 0 && t < 50) begin @(posedge clk); t++; end
      chk("bp_drain", 64'(exp0.size()), 64'd0);

      // Reset in the second RUN cycle discards the word
      @(posedge clk); #1 v0 = 1; x0 = {$urandom, $urandom}; rc0 = 8'($urandom);
      @(posedge clk); #1 v0 = 0;
      @(posedge clk); #1 rst = 1;
      @(posedge clk); #1 rst = 0;
      @(negedge clk);
      chk("rr_out_valid", 64'(ov0), 64'd0);
      chk("rr_in_ready", 64'(ir0), 64'd1);
      chk("rr_x_out", xo0, 64'd0);
      @(posedge clk); #1 v0 = 1; x0 = {$urandom, $urandom}; rc0 = 8'($urandom);
      @(posedge clk); #1 v0 = 0;
      t = 0;
      while (exp0.size() != 0 && t < 50) begin @(posedge clk); t++; end
      chk("rr_drain", 64'(exp0.size()), 64'd0);

      // SB48 with UNROLL=4: 1000 random vectors streamed
      @(posedge clk); #1 stream1 = 1; ord1 = 1; v1 = 1;
      x1 = {16'($urandom), $urandom}; rc1 = 8'($urandom);
      n = 0; t = 0;
      while (n < 1000 && t < 5000) begin
         @(negedge clk);
         if (ir1) n++;
         @(posedge clk); #1;
         x1 = {16'($urandom), $urandom}; rc1 = 8'($urandom);
         t++;
      end
      v1 = 0;
      t = 0;
      while (exp1.size() != 0 && t < 50) begin @(posedge clk); t++; end
      chk("d1_accepted", 64'(n), 64'd1000);
      chk("d1_drain", 64'(exp1.size()), 64'd0);
      stream1 = 0;

      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
